// File: rtl/flash_read_sequencer.sv
// Avalon-MM read initiator for flash audio playback: fetches one 32-bit word per
// sample pair and presents each half as a separate data_valid pulse.
module flash_read_sequencer #(
  parameter int unsigned        N          = 32,
  parameter int unsigned        ADDR_W     = 23,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [ADDR_W-1:0]  END_ADDR   = ADDR_W'('h7FFFF)
) (
  input  logic              fast_clock,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              direction,
  input  logic              restart,
  output logic [ADDR_W-1:0] flash_address,
  output logic              flash_read,
  input  logic              flash_waitrequest,
  input  logic [N-1:0]      flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [N-1:0]      read_data,
  output logic              data_valid,
  output logic              data_bus_select,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DATA,
    S_PRESENT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_addr;
  logic                r_half;
  logic                r_dir;
  logic                r_discard;
  logic                r_pend;
  logic                r_pend_dir;
  logic [N-1:0]        r_read_data;
  logic                r_data_valid;
  logic                r_sel;
  logic                r_overrun;

  logic                w_boundary;
  logic                w_start;
  logic                w_capture;
  logic                w_present;
  logic                w_tick_busy;
  logic                w_accept;
  logic                w_stalled;
  logic [ADDR_W-1:0]   w_addr_step;

  // The first half of a word equals the direction bit: fwd -> lower (0), bwd -> upper (1).
  assign w_boundary  = (r_half == r_dir);
  assign w_tick_busy = sample_tick && (r_state != S_IDLE) && !restart;
  assign w_accept    = (r_state == S_ISSUE) && !flash_waitrequest;
  assign w_stalled   = (r_state == S_ISSUE) && flash_waitrequest;

  always_comb begin
    w_addr_step = r_addr;
    if (r_dir) begin
      w_addr_step = (r_addr == START_ADDR) ? END_ADDR : r_addr - ADDR_W'(1);
    end else begin
      w_addr_step = (r_addr == END_ADDR) ? START_ADDR : r_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge fast_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_present   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sample_tick && play && !restart) begin
          w_start     = 1'b1;
          w_state_nxt = w_boundary ? S_ISSUE : S_PRESENT;
        end
      end
      S_ISSUE: begin
        if (!flash_waitrequest) begin
          w_state_nxt = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (flash_readdatavalid) begin
          if (r_discard || restart) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        w_present   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge fast_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= START_ADDR;
      r_half       <= 1'b0;
      r_dir        <= 1'b0;
      r_discard    <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_dir   <= 1'b0;
      r_read_data  <= '0;
      r_data_valid <= 1'b0;
      r_sel        <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;

      if (w_capture) begin
        r_read_data <= flash_readdata;
      end

      if (w_present) begin
        r_data_valid <= 1'b1;
        r_sel        <= r_half;
      end

      if (restart) begin
        r_overrun <= 1'b0;
      end else if (w_tick_busy) begin
        r_overrun <= 1'b1;
      end

      if ((r_state == S_WAIT_DATA) && flash_readdatavalid) begin
        r_discard <= 1'b0;
      end else if (restart && ((r_state == S_ISSUE) || (r_state == S_WAIT_DATA))) begin
        r_discard <= 1'b1;
      end

      // A restart while the read is stalled must not move the address under the
      // pending request, so the reload is deferred until the read is accepted.
      if (restart && w_stalled) begin
        r_pend     <= 1'b1;
        r_pend_dir <= direction;
      end else if (restart) begin
        r_pend <= 1'b0;
        r_addr <= direction ? END_ADDR : START_ADDR;
        r_half <= direction;
        r_dir  <= direction;
      end else if (r_pend && w_accept) begin
        r_pend <= 1'b0;
        r_addr <= r_pend_dir ? END_ADDR : START_ADDR;
        r_half <= r_pend_dir;
        r_dir  <= r_pend_dir;
      end else if (w_start && w_boundary) begin
        r_dir  <= direction;
        r_half <= direction;
      end else if (w_present) begin
        r_half <= ~r_half;
        if (!w_boundary) begin
          r_addr <= w_addr_step;
        end
      end
    end
  end

  assign flash_address   = r_addr;
  assign flash_read      = (r_state == S_ISSUE);
  assign read_data       = r_read_data;
  assign data_valid      = r_data_valid;
  assign data_bus_select = r_sel;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Directed bench for flash_read_sequencer with a small Avalon flash responder
// (fixed two-cycle read latency) and a data_valid monitor.
module tb_flash_read_sequencer;

  logic        fast_clock = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic        play;
  logic        direction;
  logic        restart;
  logic [22:0] flash_address;
  logic        flash_read;
  logic        flash_waitrequest;
  logic [31:0] flash_readdata = '0;
  logic        flash_readdatavalid = 1'b0;
  logic [31:0] read_data;
  logic        data_valid;
  logic        data_bus_select;
  logic        overrun;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          dv_cnt = 0;
  logic [31:0] dv_data = '0;
  logic        dv_sel = 1'b0;
  int          rd_cnt = 0;
  logic [22:0] rd_addr = '0;

  flash_read_sequencer #(
    .N          (32),
    .ADDR_W     (23),
    .START_ADDR (23'd0),
    .END_ADDR   (23'd3)
  ) dut (
    .fast_clock          (fast_clock),
    .reset_n             (reset_n),
    .sample_tick         (sample_tick),
    .play                (play),
    .direction           (direction),
    .restart             (restart),
    .flash_address       (flash_address),
    .flash_read          (flash_read),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .read_data           (read_data),
    .data_valid          (data_valid),
    .data_bus_select     (data_bus_select),
    .overrun             (overrun)
  );

  always #5 fast_clock = ~fast_clock;

  function automatic logic [31:0] mem(input logic [22:0] a);
    if (a == 23'd0) return 32'hBEEF1234;
    return {16'hA000 | 16'(a), 16'h5000 | 16'(a)};
  endfunction

  // Inputs change at negedge, DUT outputs are sampled at +1, flash responds at +2.
  always @(negedge fast_clock) begin
    #1;
    if (data_valid) begin
      dv_cnt++;
      dv_data = read_data;
      dv_sel  = data_bus_select;
    end
  end

  always @(negedge fast_clock) begin
    #2;
    flash_readdatavalid = 1'b0;
    if (rd_cnt != 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        flash_readdatavalid = 1'b1;
        flash_readdata      = mem(rd_addr);
      end
    end
    if (flash_read && !flash_waitrequest) begin
      rd_cnt  = 2;
      rd_addr = flash_address;
      n_acc++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_tick();
    @(negedge fast_clock);
    sample_tick = 1'b1;
    @(negedge fast_clock);
    sample_tick = 1'b0;
  endtask

  task automatic wait_dv(input string tag, input int c0, output int lat);
    lat = 0;
    while (dv_cnt == c0 && lat < 20) begin
      @(negedge fast_clock);
      #2;
      lat++;
    end
    check({tag, "_timeout"}, 64'(lat < 20), 64'd1);
  endtask

  task automatic tick_wait(input string tag, output int lat);
    int c0;
    c0 = dv_cnt;
    pulse_tick();
    wait_dv(tag, c0, lat);
  endtask

  task automatic expect_sample(input string tag, input logic sel, input logic [31:0] data);
    int lat;
    tick_wait(tag, lat);
    check({tag, "_sel"}, 64'(dv_sel), 64'(sel));
    check({tag, "_data"}, 64'(dv_data), 64'(data));
  endtask

  initial begin
    int lat;
    int a0;
    int c0;

    reset_n           = 1'b0;
    sample_tick       = 1'b0;
    play              = 1'b0;
    direction         = 1'b0;
    restart           = 1'b0;
    flash_waitrequest = 1'b0;
    repeat (3) @(negedge fast_clock);
    check("rst_addr", 64'(flash_address), 64'd0);
    check("rst_read", 64'(flash_read), 64'd0);
    check("rst_data", 64'(read_data), 64'd0);
    check("rst_dv", 64'(data_valid), 64'd0);
    check("rst_sel", 64'(data_bus_select), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);
    reset_n = 1'b1;
    play    = 1'b1;
    repeat (2) @(negedge fast_clock);

    // forward, first word: lower then upper half
    a0 = n_acc;
    c0 = dv_cnt;
    pulse_tick();
    check("t1_read_next_cycle", 64'(flash_read), 64'd1);
    wait_dv("t1a", c0, lat);
    check("t1a_sel", 64'(dv_sel), 64'd0);
    check("t1a_data", 64'(dv_data), 64'hBEEF1234);
    check("t1a_acc", 64'(n_acc - a0), 64'd1);
    tick_wait("t1b", lat);
    check("t1b_latency", 64'(lat), 64'd1);
    check("t1b_sel", 64'(dv_sel), 64'd1);
    check("t1b_data", 64'(dv_data), 64'hBEEF1234);
    check("t1b_no_read", 64'(n_acc - a0), 64'd1);
    check("t1_addr", 64'(flash_address), 64'd1);

    // waitrequest stall: read and address held for 5 cycles, one acceptance
    @(negedge fast_clock);
    flash_waitrequest = 1'b1;
    a0 = n_acc;
    c0 = dv_cnt;
    pulse_tick();
    for (int i = 0; i < 5; i++) begin
      check("ws_read", 64'(flash_read), 64'd1);
      check("ws_addr", 64'(flash_address), 64'd1);
      @(negedge fast_clock);
    end
    check("ws_no_acc", 64'(n_acc - a0), 64'd0);
    flash_waitrequest = 1'b0;
    wait_dv("ws", c0, lat);
    check("ws_one_acc", 64'(n_acc - a0), 64'd1);
    check("ws_data", 64'(dv_data), 64'hA0015001);
    expect_sample("ws_hi", 1'b1, 32'hA0015001);
    check("ws_addr_next", 64'(flash_address), 64'd2);

    // forward wrap END_ADDR=3 -> 0
    expect_sample("w2_lo", 1'b0, 32'hA0025002);
    expect_sample("w2_hi", 1'b1, 32'hA0025002);
    expect_sample("w3_lo", 1'b0, 32'hA0035003);
    expect_sample("w3_hi", 1'b1, 32'hA0035003);
    check("wrap_fwd_addr", 64'(flash_address), 64'd0);
    a0 = n_acc;
    expect_sample("w0_lo", 1'b0, 32'hBEEF1234);
    check("wrap_fwd_read", 64'(rd_addr), 64'd0);
    check("wrap_fwd_acc", 64'(n_acc - a0), 64'd1);

    // direction flipped mid-word: upper half of addr 0 still forward, then backward
    @(negedge fast_clock);
    direction = 1'b1;
    a0 = n_acc;
    expect_sample("dir_mid", 1'b1, 32'hBEEF1234);
    check("dir_mid_no_read", 64'(n_acc - a0), 64'd0);
    check("dir_mid_addr", 64'(flash_address), 64'd1);
    expect_sample("b1_hi", 1'b1, 32'hA0015001);
    expect_sample("b1_lo", 1'b0, 32'hA0015001);
    check("b1_addr", 64'(flash_address), 64'd0);
    expect_sample("b0_hi", 1'b1, 32'hBEEF1234);
    expect_sample("b0_lo", 1'b0, 32'hBEEF1234);
    check("wrap_bwd_addr", 64'(flash_address), 64'd3);
    expect_sample("b3_hi", 1'b1, 32'hA0035003);
    check("wrap_bwd_read", 64'(rd_addr), 64'd3);
    expect_sample("b3_lo", 1'b0, 32'hA0035003);
    check("b3_addr", 64'(flash_address), 64'd2);

    // tick during WAIT_DATA -> overrun, still exactly one sample
    @(negedge fast_clock);
    direction = 1'b0;
    c0 = dv_cnt;
    pulse_tick();
    @(negedge fast_clock);
    sample_tick = 1'b1;
    @(negedge fast_clock);
    sample_tick = 1'b0;
    wait_dv("ovr", c0, lat);
    check("ovr_sel", 64'(dv_sel), 64'd0);
    check("ovr_data", 64'(dv_data), 64'hA0025002);
    repeat (10) @(negedge fast_clock);
    #2;
    check("ovr_one_dv", 64'(dv_cnt - c0), 64'd1);
    check("ovr_flag", 64'(overrun), 64'd1);
    expect_sample("ovr_hi", 1'b1, 32'hA0025002);
    check("ovr_addr", 64'(flash_address), 64'd3);

    // restart during WAIT_DATA -> data discarded, overrun cleared, address reloaded
    a0 = n_acc;
    c0 = dv_cnt;
    pulse_tick();
    @(negedge fast_clock);
    restart = 1'b1;
    @(negedge fast_clock);
    restart = 1'b0;
    repeat (10) @(negedge fast_clock);
    #2;
    check("rs_acc", 64'(n_acc - a0), 64'd1);
    check("rs_no_dv", 64'(dv_cnt - c0), 64'd0);
    check("rs_ovr", 64'(overrun), 64'd0);
    check("rs_addr", 64'(flash_address), 64'd0);
    check("rs_data_kept", 64'(read_data), 64'hA0025002);
    expect_sample("rs_next", 1'b0, 32'hBEEF1234);
    expect_sample("rs_next_hi", 1'b1, 32'hBEEF1234);

    // asynchronous reset while a read is stalled in ISSUE
    @(negedge fast_clock);
    flash_waitrequest = 1'b1;
    pulse_tick();
    check("ar_pre_read", 64'(flash_read), 64'd1);
    check("ar_pre_addr", 64'(flash_address), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("ar_read", 64'(flash_read), 64'd0);
    check("ar_addr", 64'(flash_address), 64'd0);
    @(negedge fast_clock);
    flash_waitrequest = 1'b0;
    reset_n = 1'b1;
    play = 1'b0;

    // paused: ticks produce no reads and no samples
    a0 = n_acc;
    c0 = dv_cnt;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      repeat (3) @(negedge fast_clock);
    end
    #2;
    check("pause_no_read", 64'(n_acc - a0), 64'd0);
    check("pause_no_dv", 64'(dv_cnt - c0), 64'd0);
    check("pause_ovr", 64'(overrun), 64'd0);
    check("pause_addr", 64'(flash_address), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
